// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared widths and write-back entry type for the register write-back arbiter
package reg_wb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic                      tid;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

  function automatic logic entry_match(input wb_entry_t e,
                                       input logic [REG_ADDR_WIDTH-1:0] a,
                                       input logic t);
    return (e.addr == a) && (e.tid == t);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// rtl/reg_wb_arbiter_fifo.sv - wb_fifo: per-requester write queue with hazard match over valid entries
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  wb_entry_t                 i_push_entry,
  input  logic                      i_pop,
  output wb_entry_t                 o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [CW-1:0]             o_count,
  input  logic [REG_ADDR_WIDTH-1:0] i_q_addr,
  input  logic                      i_q_tid,
  output logic                      o_hit
);

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  // Pointers are PW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr] <= i_push_entry;
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && entry_match(r_mem[i], i_q_addr, i_q_tid)) o_hit = 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - two-requester register write-back arbiter with output register and hazard query
// WB_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise requester 1 has fixed priority.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PEND_W = $clog2(2 * FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
  input  logic                      req0_tid,
  input  logic [DATA_WIDTH-1:0]     req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
  input  logic                      req1_tid,
  input  logic [DATA_WIDTH-1:0]     req1_data,
  output logic                      wb_uses_rw,
  output logic [REG_ADDR_WIDTH-1:0] wb_rw_addr,
  output logic                      wb_tid,
  output logic [DATA_WIDTH-1:0]     wb_rw_data,
  input  logic [REG_ADDR_WIDTH-1:0] q_addr,
  input  logic                      q_tid,
  output logic                      q_hit,
  output logic [PEND_W-1:0]         pending
);

  wb_entry_t     w_head0, w_head1;
  logic          w_full0, w_full1;
  logic          w_empty0, w_empty1;
  logic [CW-1:0] w_cnt0, w_cnt1;
  logic          w_hit0, w_hit1;
  logic          w_push0, w_push1;
  logic          w_grant0, w_grant1;
  wb_entry_t     r_wb_entry;
  logic          r_wb_valid;

  assign req0_ready = ~w_full0;
  assign req1_ready = ~w_full1;

  // Writes to r0 are handshaken but never queued.
  assign w_push0 = req0_valid & req0_ready & (req0_addr != '0);
  assign w_push1 = req1_valid & req1_ready & (req1_addr != '0);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push0),
    .i_push_entry ('{addr: req0_addr, tid: req0_tid, data: req0_data}),
    .i_pop        (w_grant0),
    .o_head       (w_head0),
    .o_full       (w_full0),
    .o_empty      (w_empty0),
    .o_count      (w_cnt0),
    .i_q_addr     (q_addr),
    .i_q_tid      (q_tid),
    .o_hit        (w_hit0)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push1),
    .i_push_entry ('{addr: req1_addr, tid: req1_tid, data: req1_data}),
    .i_pop        (w_grant1),
    .o_head       (w_head1),
    .o_full       (w_full1),
    .o_empty      (w_empty1),
    .o_count      (w_cnt1),
    .i_q_addr     (q_addr),
    .i_q_tid      (q_tid),
    .o_hit        (w_hit1)
  );

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!w_empty0 && !w_empty1) begin
      w_grant0 = ~r_ptr;
      w_grant1 = r_ptr;
    end else begin
      w_grant0 = ~w_empty0;
      w_grant1 = ~w_empty1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_grant0) begin
      r_ptr <= 1'b1;
    end else if (w_grant1) begin
      r_ptr <= 1'b0;
    end
  end
`else
  always_comb begin
    w_grant1 = ~w_empty1;
    w_grant0 = ~w_empty0 & w_empty1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_entry <= '0;
    end else begin
      r_wb_valid <= w_grant0 | w_grant1;
      if (w_grant1) begin
        r_wb_entry <= w_head1;
      end else if (w_grant0) begin
        r_wb_entry <= w_head0;
      end
    end
  end

  assign wb_uses_rw = r_wb_valid;
  assign wb_rw_addr = r_wb_entry.addr;
  assign wb_tid     = r_wb_entry.tid;
  assign wb_rw_data = r_wb_entry.data;

  assign q_hit = (q_addr != '0) &
                 (w_hit0 | w_hit1 | (r_wb_valid & entry_match(r_wb_entry, q_addr, q_tid)));

  assign pending = PEND_W'(w_cnt0) + PEND_W'(w_cnt1);

endmodule
